// File: rtl/tns_sched_pkg.sv
// rtl/tns_sched_pkg.sv - shared types and constants for the TNS link scheduler
package tns_sched_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GRANT = 2'd2
  } sched_state_t;

  // Word driven into the encoder whenever no beat is accepted
  localparam int IDLE_WORD      = 0;
  localparam int DEF_SYNC_BEATS = 4;
  localparam int DEF_MAX_BURST  = 8;

endpackage

// File: rtl/tns_rr_arbiter.sv
// rtl/tns_rr_arbiter.sv - combinational round-robin winner select with burst hold
module tns_rr_arbiter
  import tns_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [TAG_W-1:0]   owner,
  input  logic               hold,
  output logic [NUM_REQ-1:0] grant,
  output logic [TAG_W-1:0]   grant_idx,
  output logic               grant_any
);

  // Owner keeps the link while holding; otherwise scan from owner+1, owner last
  always_comb begin
    int               idx;
    logic [TAG_W-1:0] sel;
    logic             found;
    grant     = '0;
    grant_idx = owner;
    grant_any = 1'b0;
    found     = 1'b0;
    idx       = 0;
    sel       = '0;
    if (hold && req_valid[owner]) begin
      grant[owner] = 1'b1;
      grant_any    = 1'b1;
      found        = 1'b1;
    end
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(owner) + i) % NUM_REQ;
      sel = idx[TAG_W-1:0];
      if (!found && req_valid[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tns_link_scheduler.sv
// rtl/tns_link_scheduler.sv - sync sequencer and round-robin feeder for the shared TNS encoder
module tns_link_scheduler
  import tns_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 20,
  parameter int DATA_MAX   = 2**DATA_W-1,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int SYNC_BEATS = DEF_SYNC_BEATS,
  parameter int TAG_W      = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         enc_datain,
  output logic                      out_valid,
  output logic [TAG_W-1:0]          out_tag,
  output logic                      err_range,
  output logic                      sync_done
);

  localparam logic [DATA_W-1:0] DATA_MAX_W  = DATA_W'(DATA_MAX);
  localparam logic [DATA_W-1:0] IDLE_W      = DATA_W'(IDLE_WORD);
  localparam logic [7:0]        MAX_BURST_B = 8'(MAX_BURST);
  localparam logic [7:0]        SYNC_LAST   = 8'(SYNC_BEATS - 1);

  sched_state_t        state_q, state_d;
  logic [TAG_W-1:0]    owner_q;
  logic [7:0]          beat_cnt_q;
  logic [7:0]          sync_cnt_q;

  logic [NUM_REQ-1:0]  win_onehot;
  logic [TAG_W-1:0]    win_idx;
  logic                win_any;
  logic                hold;
  logic                accept;
  logic [DATA_W-1:0]   lane [NUM_REQ];
  logic [DATA_W-1:0]   win_data;
  logic                win_oor;

  // Stage 1 travels alongside enc_datain; stage 2 lines up with the codeword
  logic                v1_q;
  logic                e1_q;
  logic [TAG_W-1:0]    tag1_q;

  assign hold = (state_q == ST_GRANT) && (beat_cnt_q < MAX_BURST_B);

  tns_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W)
  ) u_arb (
    .req_valid (req_valid),
    .owner     (owner_q),
    .hold      (hold),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .grant_any (win_any)
  );

  // Split the flat request bus into per-requester lanes
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lane[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign win_data = lane[win_idx];
  assign win_oor  = win_data > DATA_MAX_W;
  assign accept   = |(req_valid & req_ready);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_SYNC;
    else       state_q <= state_d;
  end

  // FSM next state: leave SYNC after the idle run, then follow accepts
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:  state_d = (sync_cnt_q == SYNC_LAST) ? ST_IDLE : ST_SYNC;
      ST_IDLE,
      ST_GRANT: state_d = accept ? ST_GRANT : ST_IDLE;
      default:  state_d = ST_SYNC;
    endcase
  end

  // FSM outputs: ready is the winner's one-hot, suppressed while syncing
  always_comb begin
    req_ready = '0;
    if (state_q != ST_SYNC && win_any) req_ready = win_onehot;
  end

  // Count idle words after reset and flag completion once
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_cnt_q <= 8'd0;
      sync_done  <= 1'b0;
    end else if (state_q == ST_SYNC) begin
      sync_cnt_q <= sync_cnt_q + 8'd1;
      if (sync_cnt_q == SYNC_LAST) sync_done <= 1'b1;
    end
  end

  // Track owner and burst length; a new owner or a fresh grant restarts at 1
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q    <= TAG_W'(NUM_REQ - 1);
      beat_cnt_q <= 8'd0;
    end else if (accept) begin
      owner_q    <= win_idx;
      beat_cnt_q <= (state_q == ST_GRANT && win_idx == owner_q) ? beat_cnt_q + 8'd1 : 8'd1;
    end
  end

  // Stage 1: drive the encoder input, substituting the idle word for out-of-range data
  always_ff @(posedge clock) begin
    if (reset) begin
      enc_datain <= IDLE_W;
      v1_q       <= 1'b0;
      e1_q       <= 1'b0;
      tag1_q     <= '0;
    end else if (accept) begin
      enc_datain <= win_oor ? IDLE_W : win_data;
      v1_q       <= 1'b1;
      e1_q       <= win_oor;
      tag1_q     <= win_idx;
    end else begin
      enc_datain <= IDLE_W;
      v1_q       <= 1'b0;
      e1_q       <= 1'b0;
      tag1_q     <= '0;
    end
  end

  // Stage 2: sideband aligned with the encoder's registered codeword
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      err_range <= 1'b0;
    end else begin
      out_valid <= v1_q;
      out_tag   <= tag1_q;
      err_range <= e1_q;
    end
  end

endmodule

// File: tb/tb_tns_link_scheduler.sv
// tb/tb_tns_link_scheduler.sv - scoreboard bench for tns_link_scheduler
module tb_tns_link_scheduler;

  localparam int              NR   = 4;
  localparam int              DW   = 20;
  localparam logic [DW-1:0]   DMAX = 20'h7FFFF;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [NR-1:0]      req_valid = '0;
  logic [DW-1:0]      lane [NR];
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic [DW-1:0]      enc_datain;
  logic               out_valid;
  logic [1:0]         out_tag;
  logic               err_range;
  logic               sync_done;

  typedef struct {
    logic [1:0]    tag;
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [DW-1:0] prev_enc = '0;

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = lane[i];
  end

  tns_link_scheduler #(
    .NUM_REQ    (NR),
    .DATA_W     (DW),
    .DATA_MAX   (32'h7FFFF),
    .MAX_BURST  (8),
    .SYNC_BEATS (4),
    .TAG_W      (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .enc_datain (enc_datain),
    .out_valid  (out_valid),
    .out_tag    (out_tag),
    .err_range  (err_range),
    .sync_done  (sync_done)
  );

  // Output monitor: pops the scoreboard on every live codeword
  always @(negedge clock) begin
    cyc++;
    if (out_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat observed tag %0d expected none", out_tag);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        assert (cyc == mon_e.cyc) else begin
          errors++;
          $error("FAIL beat_cycle observed %0d expected %0d", cyc, mon_e.cyc);
        end
        checks++;
        assert (out_tag === mon_e.tag) else begin
          errors++;
          $error("FAIL out_tag observed %0d expected %0d", out_tag, mon_e.tag);
        end
        checks++;
        assert (prev_enc === mon_e.data) else begin
          errors++;
          $error("FAIL enc_datain observed %05h expected %05h", prev_enc, mon_e.data);
        end
        checks++;
        assert (err_range === mon_e.err) else begin
          errors++;
          $error("FAIL err_range observed %b expected %b", err_range, mon_e.err);
        end
      end
    end else if (exp_q.size() != 0) begin
      checks++;
      assert (exp_q[0].cyc > cyc) else begin
        errors++;
        $error("FAIL missing_beat observed out_valid %b expected 1 at cycle %0d", out_valid, cyc);
        void'(exp_q.pop_front());
      end
    end
    prev_enc = enc_datain;
  end

  task automatic cyc_start();
    @(negedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_ready(input logic [NR-1:0] exp, input string name);
    #1;
    checks++;
    assert (req_ready === exp) else begin
      errors++;
      $error("FAIL %s req_ready observed %b expected %b", name, req_ready, exp);
    end
  endtask

  task automatic set_lanes();
    for (int i = 0; i < NR; i++) lane[i] = DW'($urandom_range(0, 32'h7FFFF));
  endtask

  // One cycle of stimulus; tag >= 0 names the requester expected to win
  task automatic drive(input logic [NR-1:0] v, input int tag);
    exp_t          e;
    logic [1:0]    t;
    logic [NR-1:0] r;
    cyc_start();
    set_lanes();
    req_valid = v;
    r = '0;
    if (tag >= 0) begin
      t     = 2'(tag);
      r     = NR'(1) << t;
      e.tag = t;
      e.data = lane[t];
      e.err = 1'b0;
      e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
    check_ready(r, "ready");
  endtask

  task automatic drive_val(input logic [1:0] t, input logic [DW-1:0] d);
    exp_t e;
    cyc_start();
    set_lanes();
    lane[t]   = d;
    req_valid = NR'(1) << t;
    e.tag  = t;
    e.err  = (d > DMAX);
    e.data = e.err ? '0 : d;
    e.cyc  = cyc + 2;
    exp_q.push_back(e);
    check_ready(NR'(1) << t, "ready_range");
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) drive('0, -1);
  endtask

  // Reset for one edge, then walk the sync phase expecting no readiness
  task automatic do_reset(input logic [NR-1:0] v);
    reset     = 1'b1;
    req_valid = v;
    exp_q.delete();
    cyc_start();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sync_done", 32'(sync_done), 32'd0);
    chk("rst_enc", 32'(enc_datain), 32'd0);
    chk("rst_err", 32'(err_range), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    check_ready('0, "sync_ready");
    for (int i = 1; i < 4; i++) begin
      cyc_start();
      chk("sync_done_low", 32'(sync_done), 32'd0);
      check_ready('0, "sync_ready");
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) lane[i] = '0;

    // Requester 0 waiting through sync, then streams one beat per cycle
    do_reset(4'b0001);
    drive(4'b0001, 0);
    chk("sync_done_high", 32'(sync_done), 32'd1);
    for (int i = 0; i < 9; i++) drive(4'b0001, 0);

    // Quiet link after sync: idle word only, no live codewords
    for (int i = 0; i < 22; i++) begin
      drive('0, -1);
      if (i >= 2) begin
        chk("idle_enc", 32'(enc_datain), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
      end
    end

    // All requesters busy: bursts of eight rotating 0,1,2,3,0
    do_reset('0);
    for (int k = 0; k < 40; k++) drive(4'b1111, (k / 8) % 4);
    drain();

    // Requester 2 drops after 3 beats; 1 takes over at once, then scan resumes from 2
    for (int k = 0; k < 3; k++) drive(4'b0100, 2);
    for (int k = 0; k < 8; k++) drive(4'b0010, 1);
    drive(4'b0111, 2);
    drive(4'b0011, 0);
    drain();

    // Range substitution around DATA_MAX
    drive_val(2'd0, 20'hFFFFF);
    drive_val(2'd0, 20'h7FFFF);
    drive_val(2'd0, 20'h80000);
    drain();

    // Reset mid-burst with beats in flight: they vanish and sync re-runs
    for (int k = 0; k < 5; k++) drive(4'b1000, 3);
    cyc_start();
    do_reset(4'b1000);
    for (int k = 0; k < 3; k++) drive(4'b1000, 3);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) drive('0, -1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
